// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus: the sequencer is the master, instruction memory the slave.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and fetch sequencer (BOOT/FETCH/DELIVER/HALTED).
// Optional return-address stack is built when PC_SEQ_RAS_EN is defined.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  pc_fetch_sequencer_if.master imem,
  output logic                 fetch_valid,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  input  logic                 call,
  input  logic                 ret,
  input  logic                 halt,
  output logic [31:0]          pc,
  output logic                 halted,
  output logic                 ras_err
);

  typedef enum logic [1:0] {BOOT, FETCH, DELIVER, HALTED} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] pc_seq;
  logic [31:0] pc_next;
  logic [31:0] ras_top;
  logic        ret_hit;
  logic        push;
  logic        leave;

  assign pc_seq         = pc + 32'd4;
  assign leave          = (state == DELIVER) && !stall && !halt;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

`ifdef PC_SEQ_RAS_EN
  localparam int            PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   RAS_FULL = RAS_DEPTH[PW:0];

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_sp;     // next free slot; top of stack is ras_sp-1
  logic [PW:0]   ras_count;

  assign ras_top = ras_mem[ras_sp - 1'b1];
  assign ret_hit = ret && (ras_count != '0);
`else
  logic unused_cfg;

  assign ras_top    = 32'h0;
  assign ret_hit    = 1'b0;
  assign ras_err    = 1'b0;
  assign unused_cfg = &{1'b0, push, ret, leave, RAS_DEPTH > 0};
`endif

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    pc_next = pc_seq;
    push    = 1'b0;
    if (ret_hit) begin
      pc_next = ras_top;
      push    = call;
    end else if (redirect_valid) begin
      pc_next = redirect_target & 32'hFFFF_FFFC;
      push    = call;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            state       <= DELIVER;
            req_q       <= 1'b0;
            fetch_valid <= 1'b1;
          end
        end
        DELIVER: begin
          if (!stall) begin
            fetch_valid <= 1'b0;
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
              pc    <= pc_next;
              req_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_SEQ_RAS_EN
  // call+ret on a non-empty stack replaces the top in place, so pointer and count hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ras_sp    <= '0;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else begin
      ras_err <= 1'b0;
      if (leave) begin
        if (ret_hit) begin
          if (!call) begin
            ras_sp    <= ras_sp - 1'b1;
            ras_count <= ras_count - 1'b1;
          end
        end else begin
          if (ret) ras_err <= 1'b1;
          if (push) begin
            ras_sp <= ras_sp + 1'b1;
            if (ras_count == RAS_FULL) ras_err   <= 1'b1;
            else                       ras_count <= ras_count + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: stack storage has no reset; ras_count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (leave && push) begin
      if (ret_hit) ras_mem[ras_sp - 1'b1] <= pc_seq;
      else         ras_mem[ras_sp]        <= pc_seq;
    end
  end
`endif

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the single-issue RISC core. It issues requests to instruction memory and handshakes on acknowledge. Once an instruction is delivered, it chooses the next PC from sequential, redirect (branch/jump), call or return, and halt. An optional return-address stack (RAS) predicts return targets.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- RAS_DEPTH, 4: RAS entries (power of two, 2..16). Used only when the RAS is compiled in.

- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ack  in  1  instruction memory has returned data for imem_addr.
- fetch_valid  out  1  the instruction at pc is available to decode.
- stall  in  1  decode not ready; hold the current instruction.
- redirect_valid  in  1  take redirect_target as the next PC.
- redirect_target  in  32  branch/jump target; bits [1:0] are ignored and forced to 0.
- call  in  1  the current instruction is a call; qualifies redirect_valid.
- ret  in  1  the current instruction is a return.
- halt  in  1  stop fetching.
- pc  out  32  current program counter.
- halted  out  1  sequencer is in HALTED.
- ras_err  out  1  one-cycle pulse on RAS underflow or overflow.

## Operation
- States: BOOT, FETCH, DELIVER, HALTED. Encoding is free.
- BOOT:
  - Entered on reset. pc=RESET_PC, all outputs 0.
  - Moves to FETCH unconditionally on the first clock edge after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack=1 → DELIVER.
  - imem_req stays high until ack arrives, with no timeout.
  - Control inputs are ignored in FETCH.
- DELIVER:
  - fetch_valid=1, imem_req=0.
  - stall=1 → remain in DELIVER. pc and fetch_valid hold. Control inputs are ignored.
  - stall=0 → update the PC and leave DELIVER. The PC is chosen by priority, first match wins:
    1. halt → HALTED, pc unchanged.
    2. ret (RAS compiled in, RAS non-empty) → pop; pc=popped value.
    3. redirect_valid → pc=redirect_target & ~3. If call=1 as well, push pc+4.
    4. otherwise → pc=pc+4.
  - After any case except halt, go to FETCH.
- ret with an empty RAS, or ret with the RAS compiled out:
  - The ret is treated as a plain redirect using redirect_valid/redirect_target; falls to case 3 or 4.
  - With the RAS compiled in, ras_err pulses.
- call and ret together with the RAS compiled in: pop then push pc+4. The top entry is replaced and pc=popped value.
- RAS push when full: the oldest entry is overwritten (circular buffer), the count stays at RAS_DEPTH, and ras_err pulses.
- Arithmetic is modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
- HALTED: halted=1, imem_req=0, fetch_valid=0. Only reset leaves this state.
- Reset asserted in any state:
  - Immediately forces BOOT, pc=RESET_PC, and all outputs to 0.
  - Clears the RAS count.
  - Any outstanding fetch is abandoned, and a late imem_ack is ignored.

## Timing
- Minimum fetch cycle is 2 clocks per instruction: FETCH with ack in the same cycle, then one DELIVER cycle.
- Memory latency of N wait cycles gives N+2 clocks per instruction.
- pc, state, RAS and ras_err are all registered outputs. imem_req, imem_addr and fetch_valid decode from state and pc only, with no combinational path from any input.
- The new pc is visible on the edge that leaves DELIVER and appears on imem_addr in the same cycle FETCH begins.
- ras_err is high for exactly the one cycle after the offending edge.

## Configuration
- PC_SEQ_RAS_EN defined: the RAS of RAS_DEPTH entries is built, and call/ret behave as described above.
- PC_SEQ_RAS_EN undefined:
  - No RAS storage is built.
  - call is ignored and ret behaves as a plain redirect.
  - ras_err is tied to 0.
  - The RAS_DEPTH parameter is accepted but unused.

## Test plan
- Boot and sequential fetch:
  - Stimulus: RESET_PC=0, imem_ack tied 1.
  - Required: imem_addr sequence 0,4,8,C, with fetch_valid high every second cycle.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles, then stall for 2 cycles in DELIVER.
  - Required: imem_req held for 4 cycles, fetch_valid held 3 cycles, pc unchanged throughout.
- Redirect and wrap:
  - Stimulus: redirect to 32'h0000_1003. Separately, pc=32'hFFFF_FFFC with no redirect.
  - Required: next pc is 32'h1000 for the redirect; the wrap case gives pc=0.
- Call/return (PC_SEQ_RAS_EN defined):
  - Stimulus: call at pc=0x20 with target 0x100, then ret with redirect_valid=0.
  - Required: pc goes to 0x100, then back to 0x24.
- RAS overflow/underflow (depth 4):
  - Stimulus: 5 nested calls, then 5 rets.
  - Required: ras_err pulses on the 5th push; the first 4 rets return the correct addresses; the 5th ret pulses ras_err and falls through to pc+4.
- Halt and async reset:
  - Stimulus: halt in DELIVER, then reset asserted mid-cycle.
  - Required: halted=1 and imem_req=0 while halted. On reset assertion, outputs clear immediately without waiting for a clock edge, and pc=RESET_PC.
